// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit slice.
// Imported by the baud generator and the transmitter top.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int UART_COUNT   = 2608;
    localparam int UART_DBIT    = 8;
    localparam int UART_SB_TICK = 16;
    localparam int UART_OVS     = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider producing a one-clock tick every COUNT clocks.
// The tick is decoded from the counter, so it is high while counter == COUNT-1.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int COUNT = UART_COUNT
) (
    input  logic clock,
    input  logic reset,
    output logic baud_tick
);

    localparam int CW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign baud_tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter: baud divider plus start/data/stop serialiser.
// tx and tx_done are registered so the line never glitches.
module uart_tx_unit
    import uart_pkg::*;
#(
    parameter int COUNT   = UART_COUNT,
    parameter int DBIT    = UART_DBIT,
    parameter int SB_TICK = UART_SB_TICK,
    parameter int OVS     = UART_OVS
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            tx_start,
    input  logic [DBIT-1:0] data_in,
    output logic            tx,
    output logic            tx_done,
    output logic            baud_tick
);

    localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] OVS_LAST = S_W'(OVS - 1);
    localparam logic [S_W-1:0] SB_LAST  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST   = N_W'(DBIT - 1);

    tx_state_t       state;
    logic [S_W-1:0]  s;
    logic [N_W-1:0]  n;
    logic [DBIT-1:0] b;

    uart_baud_gen #(
        .COUNT (COUNT)
    ) u_baud (
        .clock     (clock),
        .reset     (reset),
        .baud_tick (baud_tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        b     <= data_in;
                        s     <= '0;
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (s == OVS_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            tx    <= b[0];
                            state <= DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (s == OVS_LAST) begin
                            s <= '0;
                            b <= b >> 1;
                            // Next line value is the bit about to reach b[0]
                            if (n == N_LAST) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                n  <= n + 1'b1;
                                tx <= b[1];
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (s == SB_LAST) begin
                            s       <= '0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit with COUNT=4 (one bit = 64 clocks).
// Frames are captured per clock and checked at mid-bit sample points.
module tb_uart_tx_unit;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] data_in;
    logic       tx;
    logic       tx_done;
    logic       baud_tick;

    int tests;
    int fails;

    logic cap_tx   [0:1499];
    logic cap_done [0:1499];

    uart_tx_unit #(
        .COUNT   (4),
        .DBIT    (8),
        .SB_TICK (16),
        .OVS     (16)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .tx_start  (tx_start),
        .data_in   (data_in),
        .tx        (tx),
        .tx_done   (tx_done),
        .baud_tick (baud_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the start bit, then records len clocks from it.
    task automatic capture(input int len);
        int waited;
        waited = 0;
        while (tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check("start_timeout", 32'(waited < 2000), 32'd1);
        for (int i = 0; i < len; i++) begin
            cap_tx[i]   = tx;
            cap_done[i] = tx_done;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] val,
                               output int done_idx);
        int ones;
        check($sformatf("%s_start", tag), 32'(cap_tx[base+32]), 32'd0);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s_bit%0d", tag, k), 32'(cap_tx[base+96+64*k]), 32'(val[k]));
        check($sformatf("%s_stop", tag), 32'(cap_tx[base+608]), 32'd1);
        ones = 0;
        done_idx = -1;
        for (int i = base; i < base + 660; i++) begin
            if (cap_done[i] === 1'b1) begin
                ones++;
                if (done_idx < 0) done_idx = i;
            end
        end
        check($sformatf("%s_done_cnt", tag), 32'(ones), 32'd1);
        check($sformatf("%s_done_pos", tag),
              32'(done_idx >= base + 637 && done_idx <= base + 640), 32'd1);
    endtask

    function automatic int find_after(input int from, input logic v);
        for (int i = from; i < 1500; i++)
            if (cap_tx[i] === v) return i;
        return 1499;
    endfunction

    initial begin
        int d1, d2, r, f, sr, nz, dc;
        logic [7:0] tick_pat;
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        tx_start = 1'b1;
        data_in  = 8'h30;

        // Reset state while a start request is pending
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_tick", 32'(baud_tick), 32'd0);
        tx_start = 1'b0;
        reset    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            tick_pat[k] = baud_tick;
        end
        check("tick_pattern", 32'(tick_pat), 32'h44);
        check("idle_tx", 32'(tx), 32'd1);

        // Single frame 0x30 with bit-length checks
        data_in  = 8'h30;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        capture(700);
        check_frame("f30", 0, 8'h30, d1);
        r  = find_after(0, 1'b1);
        f  = find_after(r, 1'b0);
        sr = find_after(f, 1'b1);
        check("f30_b45_len", 32'(f - r), 32'd128);
        check("f30_b67_len", 32'(sr - f), 32'd128);
        check("f30_stop_len", 32'(d1 - sr), 32'd64);

        // Back-to-back frames with tx_start held high
        data_in  = 8'h30;
        tx_start = 1'b1;
        fork
            capture(1400);
            begin
                repeat (100) @(negedge clk);
                data_in = 8'h35;
                repeat (700) @(negedge clk);
                tx_start = 1'b0;
            end
        join
        check_frame("b2b1", 0, 8'h30, d1);
        nz = find_after(d1, 1'b0);
        check("b2b_gap", 32'(nz - d1), 32'd1);
        check_frame("b2b2", d1 + 1, 8'h35, d2);

        // Mid-frame data change is ignored
        data_in  = 8'hA5;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        fork
            capture(700);
            begin
                repeat (200) @(negedge clk);
                data_in = 8'h00;
            end
        join
        check_frame("fa5", 0, 8'hA5, d1);

        // Reset asserted during DATA aborts the frame
        data_in  = 8'h5A;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (200) @(negedge clk);
        check("abort_pre_tx", 32'(tx), 32'd0);
        #2 reset = 1'b0;
        #1 check("abort_tx", 32'(tx), 32'd1);
        dc = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_done === 1'b1) dc++;
        end
        check("abort_no_done", 32'(dc), 32'd0);
        data_in  = 8'hC3;
        tx_start = 1'b1;
        reset    = 1'b1;
        fork
            capture(700);
            begin
                repeat (10) @(negedge clk);
                tx_start = 1'b0;
            end
        join
        check_frame("fc3", 0, 8'hC3, d1);

        // Edge bytes
        data_in  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        capture(700);
        check_frame("f00", 0, 8'h00, d1);

        data_in  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        capture(700);
        check_frame("fff", 0, 8'hFF, d1);
        check("fff_idle", 32'(tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
